lcd1602_spi_slave: RTL and testbench

Serial-to-parallel bridge that terminates the 10-bit LCD SPI link (cs_n/sdo/sclk) driven by the LCD SPI transmitter and produces HD44780-style parallel bus cycles (RS, RW, DB[7:0], E) for the 1602 character LCD. It synchronizes the SPI pins into the system clock domain and deserializes each frame. Validated frames go into a small FIFO, and a sequencer replays them with programmable setup, enable-width and hold timing. It sits on the LCD daughterboard side of the link and doubles as the bench model of the display end.

---
 rtl/lcd1602_spi_slave.sv | 201 ++++++++++++++++++++
 tb/tb_lcd1602_spi_slave.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_spi_slave.sv
// LCD SPI link terminator: synchronizes and deserializes 10-bit frames, buffers them,
// and replays each one as an HD44780 bus cycle with programmable setup/enable/hold timing.
module lcd1602_spi_slave #(
    parameter int WIDTH      = 10,
    parameter int E_SETUP    = 2,
    parameter int E_WIDTH    = 12,
    parameter int E_HOLD     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             hz100,
    input  logic             n_rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             sdi,
    output logic             lcd_rs,
    output logic             lcd_rw,
    output logic [7:0]       lcd_db,
    output logic             lcd_e,
    output logic             frame_valid,
    output logic [WIDTH-1:0] frame_data,
    output logic             framing_err,
    output logic             overflow,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = 16;
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    // sync vectors are {sdi, cs_n, sclk}; cs_n resets high so a held-low cs_n starts a frame
    logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       prev_q, prev_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             frame_valid_q, frame_valid_d;
    logic             framing_err_q, framing_err_d;
    logic [WIDTH-1:0] frame_data_q, frame_data_d;
    logic             overflow_q, overflow_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic sclk_rise, cs_fall, cs_rise, cs_low, sdi_s;
    logic push, push_ok, pop, fifo_empty, fifo_full;
    logic [WIDTH-1:0] rd_data;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
    state_t        state_q;
    logic [TW-1:0] tmr_q;
    logic          lcd_rs_q, lcd_rw_q, lcd_e_q;
    logic [7:0]    lcd_db_q;

    assign sclk_rise  = sync2_q[0] & ~prev_q[0];
    assign cs_fall    = ~sync2_q[1] & prev_q[1];
    assign cs_rise    = sync2_q[1] & ~prev_q[1];
    assign cs_low     = ~sync2_q[1];
    assign sdi_s      = sync2_q[2];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign rd_data    = mem_q[rd_ptr_q];

    always_comb begin
        sync1_d       = {sdi, cs_n, sclk};
        sync2_d       = sync1_q;
        prev_d        = sync2_q[1:0];
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        frame_valid_d = 1'b0;
        framing_err_d = 1'b0;
        frame_data_d  = frame_data_q;
        push          = 1'b0;

        if (cs_fall) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (sclk_rise && cs_low) begin
            shift_d = {shift_q[WIDTH-2:0], sdi_s};
            if (bit_cnt_q != CNT_SAT)
                bit_cnt_d = bit_cnt_q + CW'(1);
        end

        if (cs_rise) begin
            if (bit_cnt_q == CNT_FULL) begin
                frame_valid_d = 1'b1;
                frame_data_d  = shift_q;
                push          = 1'b1;
            end else begin
                framing_err_d = 1'b1;
            end
        end

        // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
        push_ok    = push && (!fifo_full || pop);
        overflow_d = overflow_q | (push && !push_ok);
        wr_ptr_d   = wr_ptr_q + AW'(push_ok);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge hz100 or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q       <= 3'b010;
            sync2_q       <= 3'b010;
            prev_q        <= 2'b10;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            frame_valid_q <= 1'b0;
            framing_err_q <= 1'b0;
            frame_data_q  <= '0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_valid_q <= frame_valid_d;
            framing_err_q <= framing_err_d;
            frame_data_q  <= frame_data_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge hz100) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= shift_q;
    end

    // state | meaning
    // IDLE  | bus held at last frame; pops when the FIFO has an entry
    // SETUP | bus stable, lcd_e low, E_SETUP cycles
    // PULSE | lcd_e high, E_WIDTH cycles
    // HOLD  | lcd_e low, bus held, E_HOLD cycles
    always_ff @(posedge hz100 or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            lcd_rs_q <= 1'b0;
            lcd_rw_q <= 1'b0;
            lcd_db_q <= '0;
            lcd_e_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        lcd_rs_q <= rd_data[WIDTH-1];
                        lcd_rw_q <= rd_data[WIDTH-2];
                        lcd_db_q <= rd_data[7:0];
                        tmr_q    <= TW'(E_SETUP - 1);
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    if (tmr_q == '0) begin
                        lcd_e_q <= 1'b1;
                        tmr_q   <= TW'(E_WIDTH - 1);
                        state_q <= PULSE;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                PULSE: begin
                    if (tmr_q == '0) begin
                        lcd_e_q <= 1'b0;
                        tmr_q   <= TW'(E_HOLD - 1);
                        state_q <= HOLD;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                HOLD: begin
                    if (tmr_q == '0)
                        state_q <= IDLE;
                    else
                        tmr_q <= tmr_q - TW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lcd_rs      = lcd_rs_q;
    assign lcd_rw      = lcd_rw_q;
    assign lcd_db      = lcd_db_q;
    assign lcd_e       = lcd_e_q;
    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
    assign framing_err = framing_err_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_lcd1602_spi_slave.sv
// Directed bench: dut_a uses default timing, dut_b a long enable width so a burst
// of frames can fill its FIFO while the first frame is still on the bus.
module tb_lcd1602_spi_slave;
    logic hz100 = 1'b0;
    logic n_rst = 1'b0;
    logic sclk = 1'b0, sdi = 1'b0, cs_n_a = 1'b1, cs_n_b = 1'b1;

    logic       rs_a, rw_a, e_a, fv_a, fe_a, ovf_a, busy_a;
    logic [7:0] db_a;
    logic [9:0] fd_a;
    logic       rs_b, rw_b, e_b, fv_b, fe_b, ovf_b, busy_b;
    logic [7:0] db_b;
    logic [9:0] fd_b;

    int errors = 0;
    int checks = 0;

    always #5 hz100 = ~hz100;

    lcd1602_spi_slave dut_a (
        .hz100(hz100), .n_rst(n_rst), .sclk(sclk), .cs_n(cs_n_a), .sdi(sdi),
        .lcd_rs(rs_a), .lcd_rw(rw_a), .lcd_db(db_a), .lcd_e(e_a),
        .frame_valid(fv_a), .frame_data(fd_a), .framing_err(fe_a),
        .overflow(ovf_a), .busy(busy_a)
    );

    lcd1602_spi_slave #(.E_WIDTH(400)) dut_b (
        .hz100(hz100), .n_rst(n_rst), .sclk(sclk), .cs_n(cs_n_b), .sdi(sdi),
        .lcd_rs(rs_b), .lcd_rw(rw_b), .lcd_db(db_b), .lcd_e(e_b),
        .frame_valid(fv_b), .frame_data(fd_b), .framing_err(fe_b),
        .overflow(ovf_b), .busy(busy_b)
    );

    int fv_cnt_a = 0, fe_cnt_a = 0, rise_a = 0;
    int fv_cnt_b = 0, fe_cnt_b = 0, rise_b = 0;
    logic e_prev_a = 1'b0, e_prev_b = 1'b0;
    logic [7:0] db_seq_b [$];

    always @(negedge hz100) begin
        if (fv_a) fv_cnt_a <= fv_cnt_a + 1;
        if (fe_a) fe_cnt_a <= fe_cnt_a + 1;
        if (e_a && !e_prev_a) rise_a <= rise_a + 1;
        e_prev_a <= e_a;
        if (fv_b) fv_cnt_b <= fv_cnt_b + 1;
        if (fe_b) fe_cnt_b <= fe_cnt_b + 1;
        if (e_b && !e_prev_b) begin
            rise_b <= rise_b + 1;
            db_seq_b.push_back(db_b);
        end
        e_prev_b <= e_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge hz100);
    endtask

    // MSB first; sdi set with sclk low for 3 cycles, then sclk high for 3 cycles
    task automatic send_frame(input logic [31:0] bits, input int n, input bit to_b,
                              input bit cs_already_low);
        if (!cs_already_low) begin
            if (to_b) cs_n_b = 1'b0; else cs_n_a = 1'b0;
        end
        tick(3);
        for (int i = n - 1; i >= 0; i--) begin
            sdi  = bits[i];
            sclk = 1'b0;
            tick(3);
            sclk = 1'b1;
            tick(3);
        end
        sclk = 1'b0;
        if (to_b) cs_n_b = 1'b1; else cs_n_a = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int w;

        // reset state
        tick(2);
        chk("rst_e", e_a, 0);
        chk("rst_rs", rs_a, 0);
        chk("rst_db", db_a, 0);
        chk("rst_fd", fd_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ovf", ovf_a, 0);
        n_rst = 1'b1;
        tick(3);

        // single valid frame: exact latencies and pulse width
        send_frame(32'h241, 10, 0, 0);
        tick(2);
        chk("fv_early", fv_a, 0);
        tick(1);
        chk("fv_lat3", fv_a, 1);
        chk("fd_241", fd_a, 10'h241);
        chk("busy_fifo", busy_a, 1);
        tick(1);
        chk("bus_rs", rs_a, 1);
        chk("bus_rw", rw_a, 0);
        chk("bus_db", db_a, 8'h41);
        chk("e_low_setup0", e_a, 0);
        tick(1);
        chk("e_low_setup1", e_a, 0);
        tick(1);
        chk("e_rise", e_a, 1);
        w = 1;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (!e_a) break;
            w++;
        end
        chk("e_width", w, 12);
        chk("busy_hold0", busy_a, 1);
        tick(1);
        chk("busy_hold1", busy_a, 1);
        tick(1);
        chk("busy_idle", busy_a, 0);
        chk("db_held", db_a, 8'h41);

        // short, long and counter-saturating frames
        tick(3);
        send_frame(32'h1AB, 9, 0, 0);
        tick(3);
        chk("fe_9bit", fe_a, 1);
        tick(3);
        send_frame(32'h555, 11, 0, 0);
        tick(3);
        chk("fe_11bit", fe_a, 1);
        tick(3);
        send_frame(32'h2AA_AAAA, 26, 0, 0);
        tick(3);
        chk("fe_26bit", fe_a, 1);
        tick(5);
        chk("fe_count", fe_cnt_a, 3);
        chk("fv_count_bad", fv_cnt_a, 1);
        chk("no_pulse_bad", rise_a, 1);
        chk("fd_unchanged", fd_a, 10'h241);
        chk("busy_bad", busy_a, 0);

        // sclk activity with cs_n high is ignored
        for (int k = 0; k < 20; k++) begin
            sdi  = 1'($urandom_range(0, 1));
            sclk = 1'b1;
            tick(3);
            sclk = 1'b0;
            tick(3);
        end
        tick(5);
        chk("idle_fv", fv_cnt_a + fv_cnt_b, 1);
        chk("idle_fe", fe_cnt_a + fe_cnt_b, 3);
        chk("idle_pulse", rise_a + rise_b, 1);

        // burst of six frames into dut_b; sixth overflows
        for (int f = 1; f <= 6; f++) begin
            send_frame(32'(f), 10, 1, 0);
            tick(3);
            if (f == 5) chk("ovf_before6", ovf_b, 0);
        end
        chk("ovf_after6", ovf_b, 1);
        chk("fd_b_6", fd_b, 10'h006);
        // empty frame: framing error, FIFO and overflow untouched
        cs_n_b = 1'b0;
        tick(6);
        cs_n_b = 1'b1;
        tick(3);
        chk("fe_empty", fe_b, 1);
        chk("ovf_sticky", ovf_b, 1);
        for (int k = 0; k < 3000 && busy_b; k++) tick(1);
        chk("b_drain", busy_b, 0);
        tick(2);
        chk("b_pulses", rise_b, 5);
        chk("b_fv", fv_cnt_b, 6);
        chk("b_fe", fe_cnt_b, 1);
        chk("b_seq_len", db_seq_b.size(), 5);
        for (int i = 0; i < db_seq_b.size() && i < 5; i++)
            chk("b_seq_db", db_seq_b[i], 32'(i + 1));
        chk("a_ovf_clear", ovf_a, 0);

        // asynchronous reset mid-pulse
        send_frame(32'h3FF, 10, 0, 0);
        for (int k = 0; k < 30 && !e_a; k++) tick(1);
        chk("pre_rst_e", e_a, 1);
        chk("pre_rst_rw", rw_a, 1);
        chk("pre_rst_db", db_a, 8'hFF);
        tick(3);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_e", e_a, 0);
        chk("arst_rs", rs_a, 0);
        chk("arst_rw", rw_a, 0);
        chk("arst_db", db_a, 0);
        chk("arst_fd", fd_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_ovf_b", ovf_b, 0);
        cs_n_a = 1'b0;
        tick(3);
        n_rst = 1'b1;
        // cs_n held low through release starts a fresh frame
        send_frame(32'h0C0, 10, 0, 1);
        tick(2);
        chk("post_fv_early", fv_a, 0);
        tick(1);
        chk("post_fv", fv_a, 1);
        chk("post_fd", fd_a, 10'h0C0);
        tick(1);
        chk("post_rs", rs_a, 0);
        chk("post_db", db_a, 8'hC0);
        for (int k = 0; k < 60 && busy_a; k++) tick(1);
        chk("post_drain", busy_a, 0);
        tick(2);
        chk("post_pulses", rise_a, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
